// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: issue/readback bundle between the execute stage and the
// multiply/divide unit.
//   master (execute stage): drives op_valid, op, a, b, flush, rd_req;
//                           observes hi, lo, busy, done, stall
//   slave  (ex_muldiv)    : the reverse
interface ex_muldiv_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  op_valid;
   logic [3:0]            op;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  flush;
   logic                  rd_req;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;
   logic                  busy;
   logic                  done;
   logic                  stall;

   modport master (
      output op_valid, op, a, b, flush, rd_req,
      input  hi, lo, busy, done, stall
   );

   modport slave (
      input  op_valid, op, a, b, flush, rd_req,
      output hi, lo, busy, done, stall
   );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit owning the HI/LO register pair.
//   clock   : rising-edge clock
//   reset   : synchronous, active-high
//   bus     : ex_muldiv_if.slave
//     op_valid/op/a/b : issue (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB,
//                       MSUBU, MTHI, MTLO; other op codes do nothing)
//     flush           : abort an in-flight operation, drop a same-cycle issue
//     rd_req          : execute stage is reading HI/LO this cycle
//     hi/lo           : architectural HI/LO
//     busy/done/stall : in flight / one-cycle result pulse / hold issuer
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an op; MTHI/MTLO complete here in one edge
// RUN   | DATA_WIDTH shift-add (mul) or restoring (div) iterations
// FIX   | sign correction, accumulate, HI/LO write, done pulse
module ex_muldiv #(
   parameter int DATA_WIDTH = 32
) (
   input logic        clock,
   input logic        reset,
   ex_muldiv_if.slave bus
);
   localparam int              W        = DATA_WIDTH;
   localparam logic [W-1:0]    CNT_LAST = W'(W - 1);
   localparam logic [W-1:0]    CNT_ONE  = W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   // mul: {partial product, remaining multiplier bits}
   // div: {partial remainder, dividend bits shifting out / quotient in}
   logic [2*W-1:0] work_q, work_d;
   logic [W-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic           is_div_q, is_div_d;
   logic           neg_res_q, neg_res_d;
   logic           neg_rem_q, neg_rem_d;
   logic           acc_add_q, acc_add_d;
   logic           acc_sub_q, acc_sub_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic           done_q, done_d;

   logic dec_mul, dec_div, dec_signed, dec_madd, dec_msub, dec_mthi, dec_mtlo;

   always_comb begin
      dec_mul    = 1'b0;
      dec_div    = 1'b0;
      dec_signed = 1'b0;
      dec_madd   = 1'b0;
      dec_msub   = 1'b0;
      dec_mthi   = 1'b0;
      dec_mtlo   = 1'b0;
      case (bus.op)
         4'd0: begin dec_mul = 1'b1; dec_signed = 1'b1; end
         4'd1: dec_mul = 1'b1;
         4'd2: begin dec_div = 1'b1; dec_signed = 1'b1; end
         4'd3: dec_div = 1'b1;
         4'd4: begin dec_mul = 1'b1; dec_signed = 1'b1; dec_madd = 1'b1; end
         4'd5: begin dec_mul = 1'b1; dec_madd = 1'b1; end
         4'd6: begin dec_mul = 1'b1; dec_signed = 1'b1; dec_msub = 1'b1; end
         4'd7: begin dec_mul = 1'b1; dec_msub = 1'b1; end
         4'd8: dec_mthi = 1'b1;
         4'd9: dec_mtlo = 1'b1;
         default: ;
      endcase
   end

   logic         a_neg, b_neg;
   logic [W-1:0] mag_a, mag_b;

   assign a_neg = dec_signed & bus.a[W-1];
   assign b_neg = dec_signed & bus.b[W-1];
   assign mag_a = a_neg ? -bus.a : bus.a;
   assign mag_b = b_neg ? -bus.b : bus.b;

   // One iteration of each algorithm, computed from the working register.
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_trial;
   logic [2*W-1:0] div_next;

   assign mul_sum  = {1'b0, work_q[2*W-1:W]} +
                     {1'b0, (work_q[0] ? opnd_q : {W{1'b0}})};
   assign mul_next = {mul_sum, work_q[W-1:1]};
   // Remainder stays below the divisor, so the trial fits in W+1 bits; a
   // zero divisor always succeeds and yields all-ones quotient, rem = |a|.
   assign div_trial = {work_q[2*W-1:W], work_q[W-1]} - {1'b0, opnd_q};
   assign div_next  = div_trial[W] ? {work_q[2*W-2:0], 1'b0}
                                   : {div_trial[W-1:0], work_q[W-2:0], 1'b1};

   logic [2*W-1:0] hilo, mul_res, mul_fix;
   logic [W-1:0]   quot_fix, rem_fix;

   assign hilo     = {hi_q, lo_q};
   assign mul_res  = neg_res_q ? -work_q : work_q;
   assign mul_fix  = acc_add_q ? (hilo + mul_res) :
                     acc_sub_q ? (hilo - mul_res) : mul_res;
   assign quot_fix = neg_res_q ? -work_q[W-1:0]   : work_q[W-1:0];
   assign rem_fix  = neg_rem_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_add_d = acc_add_q;
      acc_sub_d = acc_sub_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.op_valid && !bus.flush) begin
               if (dec_mul || dec_div) begin
                  state_d   = S_RUN;
                  cnt_d     = '0;
                  is_div_d  = dec_div;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  acc_add_d = dec_madd;
                  acc_sub_d = dec_msub;
                  if (dec_div) begin
                     work_d = {{W{1'b0}}, mag_a};
                     opnd_d = mag_b;
                  end else begin
                     work_d = {{W{1'b0}}, mag_b};
                     opnd_d = mag_a;
                  end
               end else if (dec_mthi) begin
                  hi_d = bus.a;
               end else if (dec_mtlo) begin
                  lo_d = bus.a;
               end
            end
         end

         S_RUN: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               work_d = is_div_q ? div_next : mul_next;
               cnt_d  = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            state_d = S_IDLE;
            if (!bus.flush) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  hi_d = mul_fix[2*W-1:W];
                  lo_d = mul_fix[W-1:0];
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_add_q <= 1'b0;
         acc_sub_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_add_q <= acc_add_d;
         acc_sub_q <= acc_sub_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = (state_q != S_IDLE);
   assign bus.done  = done_q;
   assign bus.stall = bus.busy & (bus.op_valid | bus.rd_req);
endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [W-1:0] hi_m = '0;
   logic [W-1:0] lo_m = '0;

   ex_muldiv_if #(.DATA_WIDTH(W)) bus ();

   ex_muldiv #(.DATA_WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Architectural reference: full-width arithmetic on the operand values.
   task automatic ref_update(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] p, acc;
      longint      sa, sb, q, r;
      logic [63:0] ua, ub;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      acc = {hi_m, lo_m};
      case (op)
         4'd0, 4'd4, 4'd6: p = sa * sb;
         4'd1, 4'd5, 4'd7: p = ua * ub;
         default:          p = '0;
      endcase
      case (op)
         4'd0, 4'd1: {hi_m, lo_m} = p;
         4'd4, 4'd5: {hi_m, lo_m} = acc + p;
         4'd6, 4'd7: {hi_m, lo_m} = acc - p;
         4'd2: begin
            if (b == 0) begin
               lo_m = a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF;
               hi_m = a;
            end else begin
               q = sa / sb;
               r = sa % sb;
               lo_m = q[31:0];
               hi_m = r[31:0];
            end
         end
         4'd3: begin
            if (b == 0) begin
               lo_m = 32'hFFFF_FFFF;
               hi_m = a;
            end else begin
               lo_m = a / b;
               hi_m = a % b;
            end
         end
         4'd8: hi_m = a;
         4'd9: lo_m = a;
         default: ;
      endcase
   endtask

   // Issues in the current cycle; returns at the negedge of the completion
   // cycle. mode 1 holds rd_req while busy, mode 2 attempts an MTHI while busy.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int mode);
      int k;
      int bc;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.op_valid = 1'b1;
      #1;
      chk("stall_at_issue", bus.stall, 0);
      ref_update(op, a, b);
      @(negedge clock);
      bus.op_valid = 1'b0;
      if (op > 4'd7) begin
         chk("short_busy", bus.busy, 0);
         chk("short_done", bus.done, 0);
         chk("short_hi", bus.hi, hi_m);
         chk("short_lo", bus.lo, lo_m);
      end else begin
         k  = 1;
         bc = 0;
         while (bus.done !== 1'b1 && k < 60) begin
            if (mode == 1) bus.rd_req = 1'b1;
            if (mode == 2) begin
               bus.op       = 4'd8;
               bus.a        = 32'hDEAD_BEEF;
               bus.op_valid = 1'b1;
            end
            #1;
            if (bus.busy === 1'b1) bc++;
            if (mode != 0) chk("stall_while_busy", bus.stall, 1);
            @(negedge clock);
            bus.op_valid = 1'b0;
            k++;
         end
         if (mode == 1) begin
            #1;
            chk("stall_rd_done", bus.stall, 0);
            bus.rd_req = 1'b0;
         end
         chk("latency", k, 34);
         chk("busy_cycles", bc, 33);
         chk("busy_at_done", bus.busy, 0);
         chk("hi", bus.hi, hi_m);
         chk("lo", bus.lo, lo_m);
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int dn;
      logic [3:0] rop;
      bus.op_valid = 1'b0;
      bus.op       = '0;
      bus.a        = '0;
      bus.b        = '0;
      bus.flush    = 1'b0;
      bus.rd_req   = 1'b0;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_stall", bus.stall, 0);

      // Max unsigned product, then a back-to-back issue in the done cycle.
      @(negedge clock);
      run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", bus.lo, 32'h0000_0001);
      run_op(4'd1, 32'h0001_2345, 32'h0000_6789, 0);

      // Signed multiply and accumulate chain.
      @(negedge clock);
      run_op(4'd0, -32'sd3, 32'd7, 0);
      chk("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);
      run_op(4'd4, 32'd2, 32'd5, 0);
      chk("madd_hi", bus.hi, 32'hFFFF_FFFF);
      chk("madd_lo", bus.lo, 32'hFFFF_FFF5);
      run_op(4'd6, 32'd1, 32'd1, 0);
      chk("msub_lo", bus.lo, 32'hFFFF_FFF4);

      // Divides: signed, by zero, overflow corner (with stall probes).
      @(negedge clock);
      run_op(4'd2, -32'sd7, 32'd2, 1);
      chk("div_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_hi", bus.hi, 32'hFFFF_FFFF);
      run_op(4'd3, 32'd7, 32'd0, 0);
      chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
      chk("divu0_hi", bus.hi, 32'd7);
      run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2);
      chk("div_ovf_lo", bus.lo, 32'h8000_0000);
      chk("div_ovf_hi", bus.hi, 32'h0);

      // MTHI/MTLO in consecutive cycles.
      @(negedge clock);
      run_op(4'd8, 32'h0000_1234, 32'd0, 0);
      run_op(4'd9, 32'h0000_5678, 32'd0, 0);
      chk("mt_hi", bus.hi, 32'h0000_1234);
      chk("mt_lo", bus.lo, 32'h0000_5678);

      // Flush in RUN cycle 10 of a DIVU.
      @(negedge clock);
      bus.op = 4'd3; bus.a = 32'd1000; bus.b = 32'd7; bus.op_valid = 1'b1;
      @(negedge clock);
      bus.op_valid = 1'b0;
      repeat (9) @(negedge clock);
      bus.flush = 1'b1;
      @(negedge clock);
      bus.flush = 1'b0;
      chk("flush_busy", bus.busy, 0);
      dn = 0;
      repeat (40) begin
         if (bus.done === 1'b1) dn++;
         @(negedge clock);
      end
      chk("flush_no_done", dn, 0);
      chk("flush_hi", bus.hi, hi_m);
      chk("flush_lo", bus.lo, lo_m);

      // Flush in IDLE drops a simultaneous issue.
      bus.op = 4'd8; bus.a = 32'hFACE_0000; bus.op_valid = 1'b1; bus.flush = 1'b1;
      @(negedge clock);
      bus.op = 4'd0;
      @(negedge clock);
      bus.op_valid = 1'b0; bus.flush = 1'b0;
      chk("idle_flush_hi", bus.hi, hi_m);
      chk("idle_flush_busy", bus.busy, 0);

      // Reset during a MULT discards everything.
      bus.op = 4'd0; bus.a = 32'd5; bus.b = 32'd6; bus.op_valid = 1'b1;
      @(negedge clock);
      bus.op_valid = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      hi_m = '0;
      lo_m = '0;
      chk("midrst_hi", bus.hi, 0);
      chk("midrst_lo", bus.lo, 0);
      chk("midrst_busy", bus.busy, 0);
      dn = 0;
      repeat (40) begin
         if (bus.done === 1'b1) dn++;
         @(negedge clock);
      end
      chk("midrst_no_done", dn, 0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 11));
         if (rop > 4'd9) rop = 4'(10 + $urandom_range(0, 5));
         run_op(rop, pick(), pick(), int'($urandom_range(0, 2)));
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit that runs alongside the execute-stage ALU and owns the architectural HI/LO register pair. It is parametrised in data width and adds behaviour the ALU lacks: multi-cycle operation, signed and unsigned divide, multiply-accumulate (MADD/MSUB), flush abort and a stall handshake. The execute stage issues one operation at a time and reads HI/LO through this block.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width W; iteration count equals W.

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  issue strobe for op
op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; others are no-ops
a  input  W  rs operand (dividend / multiplicand / MT source)
b  input  W  rt operand (divisor / multiplier)
flush  input  1  cancels in-flight operation
rd_req  input  1  execute stage wants HI or LO this cycle (MFHI/MFLO)
hi  output  W  HI register
lo  output  W  LO register
busy  output  1  operation in flight
done  output  1  one-cycle pulse: new HI/LO visible this cycle
stall  output  1  busy & (op_valid | rd_req)

Behaviour:
- Reset (synchronous, active-high): state IDLE; hi=0, lo=0, busy=0, done=0. Takes effect mid-operation; partial results are discarded.
- Ops are accepted only in IDLE with op_valid=1. While busy, op_valid is ignored and stall=1 holds the issuer.
- MTHI/MTLO in IDLE: hi or lo <= a at the next edge. No busy, no done.
- FSM states are IDLE, RUN, FIX.
  - IDLE -> RUN on an accepted mul/div op. The accept edge latches |a| and |b| (magnitudes for signed ops, raw values for unsigned ops), the result signs, the accumulate mode and a W-bit counter=0.
  - RUN runs exactly W cycles. Mul is 1-bit shift-add over a 2W product. Div is 1-bit restoring, producing the quotient MSB first into a W-bit remainder register.
  - RUN -> FIX when the counter reaches W-1.
  - FIX (1 cycle) applies sign correction. MUL: negate the 2W product if the operand signs differ. DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign. FIX also applies accumulation: MADD/MADDU {hi,lo} <= {hi,lo}+product; MSUB/MSUBU {hi,lo} <= {hi,lo}-product. Arithmetic is 2W-bit with wraparound and no overflow flag.
  - FIX -> IDLE. HI/LO are written at the FIX edge: mul gives {hi,lo}=result; div gives lo=quotient, hi=remainder.
- Timing: an op accepted at edge t produces busy=1 from t+1 through t+W+1. At t+W+2, done=1, busy=0 and the new hi/lo are visible. Total latency is W+2 cycles. A new op may be accepted in the done cycle.
- flush: in RUN or FIX, return to IDLE at the next edge. hi/lo stay unchanged and done is not pulsed. In IDLE, flush overrides a simultaneous op_valid (op dropped).
- Divide by zero has a defined, deterministic result. Magnitude quotient = all ones, remainder = |a|, then normal sign correction applies.
- Signed -2^(W-1) / -1 gives lo=2^(W-1) (0x80000000 at W=32) and hi=0.
- rd_req while busy: stall=1 until done. In IDLE, hi/lo are combinationally valid.
- hi/lo are registered and never change outside MT writes, the FIX edge or reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at cycle t+34: done=1, hi=0xFFFFFFFE, lo=0x00000001. busy was high for 33 cycles.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MADD a=2, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF5. Then MSUB a=1, b=1 -> lo=0xFFFFFFF4.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- MTHI 0x1234, then MTLO 0x5678 in consecutive cycles -> hi=0x1234, lo=0x5678, busy never asserts. rd_req during a DIV gives stall=1 until done.
- Flush at RUN cycle 10 of a DIVU -> busy drops the next cycle, no done pulse, hi/lo keep their prior values. Reset asserted mid-MULT -> hi=lo=0, busy=0.
- Back-to-back: a second MULTU issued in the done cycle of the first is accepted (stall=0). Its result appears W+2 cycles later. An op_valid asserted while busy is ignored and stall=1.
